// File: rtl/act_feeder_pkg.sv
// Shared types and constants for the activation feeder.
`include "ftdl_conf.vh"

package act_feeder_pkg;

  // Elements per beat, taken from the global configuration header.
  localparam int HW_D1 = `HW_D1;

  // Saturation value of the stall counter.
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Feeder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/act_feeder_if.sv
// Upstream activation stream and activation-buffer write port, bundled.
interface act_feeder_if
  import act_feeder_pkg::*;
#(
  parameter int DW = HW_D1 * 8
);
  logic [DW-1:0] s_act_data;
  logic          s_act_valid;
  logic          s_act_ready;
  logic          actbuf_wr_req;
  logic          actbuf_wr_vld;
  logic [DW-1:0] actbuf_wr_data;

  // Producer / controller side: drives the stream and the write request.
  modport master (
    output s_act_data,
    output s_act_valid,
    input  s_act_ready,
    output actbuf_wr_req,
    input  actbuf_wr_vld,
    input  actbuf_wr_data
  );

  // Feeder side.
  modport slave (
    input  s_act_data,
    input  s_act_valid,
    output s_act_ready,
    input  actbuf_wr_req,
    output actbuf_wr_vld,
    output actbuf_wr_data
  );
endinterface

// File: rtl/act_fifo.sv
// Prefetch FIFO: array storage, registered read port, occupancy counter.
module act_fifo
  import act_feeder_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = fifo_ptr_w(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DW-1:0]    dout_reg;
  logic             push_ok;
  logic             pop_ok;

  // Flags come straight from the registered occupancy.
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = dout_reg;

  // Overflow and underflow are masked here so a misbehaving caller
  // cannot corrupt the pointers.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write; the array carries no reset so it maps onto RAM.
  always_ff @(posedge clk_l) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Registered read: the popped word appears on dout one cycle later.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg <= '0;
    end else if (pop_ok) begin
      dout_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy only
  // moves when exactly one of push/pop happens.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ftdl_conf.vh
// Global datapath widths shared by the feeder and the activation buffer.
`ifndef FTDL_CONF_VH
`define FTDL_CONF_VH

// Activation elements carried side by side in one beat.
`define HW_D1 4

// Address width of the activation buffer written by the feeder.
`define ACTBUF_ADDR_LEN 10

`endif

// File: rtl/act_feeder.sv
// Activation feeder: prefetches upstream words and streams one tile of
// beats into the activation buffer on request.
module act_feeder
  import act_feeder_pkg::*;
#(
  parameter int ACT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_l,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [15:0] cfg_tile_words,
  act_feeder_if.slave bus,
  output logic        status_feed,
  output logic        feed_done,
  output logic [15:0] stall_cnt
);

  localparam int DW    = HW_D1 * ACT_W;
  localparam int CNT_W = fifo_ptr_w(FIFO_DEPTH) + 1;

  state_t      state_reg, state_next;
  logic [15:0] tile_reg, tile_next;
  logic [15:0] beat_reg, beat_next;
  logic [15:0] stall_reg, stall_next;
  logic        vld_reg;
  logic        ready_en_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [DW-1:0]    fifo_dout;
  logic             push;
  logic             issue;
  logic             stall_hit;

  // Ready is held low until the first clock after reset release.
  assign bus.s_act_ready = ready_en_reg && !fifo_full;
  assign push            = bus.s_act_valid && bus.s_act_ready;

  // One beat leaves the FIFO whenever the controller asks and a word exists;
  // an ask against an empty FIFO is a stall cycle.
  assign issue     = (state_reg == FEED) && bus.actbuf_wr_req && !fifo_empty;
  assign stall_hit = (state_reg == FEED) && bus.actbuf_wr_req && (fifo_count == '0);

  assign bus.actbuf_wr_vld  = vld_reg;
  assign bus.actbuf_wr_data = fifo_dout;
  assign status_feed        = (state_reg == FEED);
  assign feed_done          = (state_reg == DONE);
  assign stall_cnt          = stall_reg;

  act_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_l (clk_l),
    .rst_n (rst_n),
    .push  (push),
    .pop   (issue),
    .din   (bus.s_act_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and counter updates; start requests only count in IDLE.
  always_comb begin
    state_next = state_reg;
    tile_next  = tile_reg;
    beat_next  = beat_reg;
    stall_next = stall_reg;

    if (stall_hit && (stall_reg != STALL_MAX)) begin
      stall_next = stall_reg + 16'd1;
    end

    case (state_reg)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_tile_words == 16'd0) begin
            state_next = DONE;
          end else begin
            state_next = FEED;
            tile_next  = cfg_tile_words;
            beat_next  = 16'd0;
            stall_next = 16'd0;
          end
        end
      end
      FEED: begin
        if (issue) begin
          beat_next = beat_reg + 16'd1;
          if (beat_reg == (tile_reg - 16'd1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state and tile bookkeeping registers.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tile_reg  <= 16'd0;
      beat_reg  <= 16'd0;
      stall_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      tile_reg  <= tile_next;
      beat_reg  <= beat_next;
      stall_reg <= stall_next;
    end
  end

  // Beat-valid follows the issue decision by one cycle, matching the
  // FIFO's registered read data.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= 1'b0;
    end else begin
      vld_reg <= issue;
    end
  end

  // Upstream ready enable: low throughout reset, high from the first edge after.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_act_feeder.sv
// Self-checking bench for act_feeder: queue-based reference model compared
// every cycle, directed tile scenarios plus randomized traffic.
module tb_act_feeder;
  import act_feeder_pkg::*;

  localparam int ACT_W = 8;
  localparam int DEPTH = 4;
  localparam int DW    = HW_D1 * ACT_W;

  logic        clk_l = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_tile_words = 16'd0;
  logic        status_feed;
  logic        feed_done;
  logic [15:0] stall_cnt;

  act_feeder_if #(.DW(DW)) bus ();

  act_feeder #(.ACT_W(ACT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_l          (clk_l),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_tile_words (cfg_tile_words),
    .bus            (bus.slave),
    .status_feed    (status_feed),
    .feed_done      (feed_done),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk_l = ~clk_l;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The tile is described as "active / just finished / idle" plus a queue
  // of words held by the prefetch buffer.
  logic [DW-1:0] q[$];
  bit            m_ready_en, m_active, m_done, exp_vld;
  int            m_tile, m_issued, m_stall;
  logic [DW-1:0] exp_data;

  always @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ready_en = 0; m_active = 0; m_done = 0; exp_vld = 0;
      m_tile = 0; m_issued = 0; m_stall = 0; exp_data = '0;
    end else begin
      int sz;
      bit do_push, do_pop;
      sz      = q.size();
      do_push = bus.s_act_valid && m_ready_en && (sz < DEPTH);
      do_pop  = m_active && bus.actbuf_wr_req && (sz > 0);
      exp_vld = do_pop;
      if (do_pop) begin
        exp_data = q.pop_front();
        m_issued++;
      end
      if (do_push) q.push_back(bus.s_act_data);
      if (m_active && bus.actbuf_wr_req && sz == 0 && m_stall < 65535) m_stall++;
      if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        if (m_issued == m_tile) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (cfg_start) begin
        if (cfg_tile_words == 16'd0) begin
          m_done = 1;
        end else begin
          m_active = 1;
          m_tile   = int'(cfg_tile_words);
          m_issued = 0;
          m_stall  = 0;
        end
      end
      m_ready_en = 1;
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int            beats_seen = 0;
  int            done_seen  = 0;
  int            run_cur    = 0;
  int            run_max    = 0;
  logic [15:0]   last_done_stall = 16'd0;
  logic [DW-1:0] prev_data;
  bit            have_prev = 0;

  always @(negedge clk_l) begin
    check("vld", 64'(bus.actbuf_wr_vld), 64'(exp_vld));
    if (exp_vld) check("data", 64'(bus.actbuf_wr_data), 64'(exp_data));
    check("status_feed", 64'(status_feed), 64'(m_active));
    check("feed_done", 64'(feed_done), 64'(m_done));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("s_act_ready", 64'(bus.s_act_ready), 64'(m_ready_en && (q.size() < DEPTH)));
    if (!rst_n) have_prev = 0;
    if (bus.actbuf_wr_vld) begin
      beats_seen++;
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
      if (have_prev) check("order", 64'(bus.actbuf_wr_data), 64'(prev_data + 1'b1));
      prev_data = bus.actbuf_wr_data;
      have_prev = 1;
      $display("beat %0d data=%h stall_cnt=%0d", beats_seen, bus.actbuf_wr_data, stall_cnt);
    end else begin
      run_cur = 0;
    end
    if (feed_done) begin
      done_seen++;
      last_done_stall = stall_cnt;
      $display("feed_done #%0d stall_cnt=%0d", done_seen, stall_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  int seq      = 1;
  int up_mode  = 0;   // 0 off, 1 always valid, 2 every third cycle, 3 random
  int up_ph    = 0;
  bit req_rand = 0;
  bit cfg_rand = 0;

  task automatic step();
    @(posedge clk_l);
    if (bus.s_act_valid && bus.s_act_ready) seq++;
    #1;
    cfg_start = 1'b0;
    case (up_mode)
      0: bus.s_act_valid = 1'b0;
      1: bus.s_act_valid = 1'b1;
      2: begin bus.s_act_valid = (up_ph % 3 == 2); up_ph++; end
      default: bus.s_act_valid = 1'($urandom_range(0, 1));
    endcase
    bus.s_act_data = DW'(seq);
    if (req_rand) bus.actbuf_wr_req = ($urandom_range(0, 3) != 0);
    if (cfg_rand && status_feed) begin
      cfg_start      = ($urandom_range(0, 7) == 0);
      cfg_tile_words = 16'($urandom_range(0, 50));
    end
  endtask

  task automatic start_tile(input int n);
    cfg_tile_words = 16'(n);
    cfg_start      = 1'b1;
    step();
  endtask

  task automatic run_until_done(input int d0, input int budget, input string tag);
    int n;
    n = 0;
    while (done_seen == d0 && n < budget) begin
      step();
      n++;
    end
    compared++;
    if (done_seen == d0) begin
      mismatched++;
      $display("FAIL %s_timeout: no feed_done after %0d cycles, required within %0d", tag, n, budget);
    end
  endtask

  task automatic wait_beats(input int b0, input int k);
    int n;
    n = 0;
    while ((beats_seen - b0) < k && n < 500) begin
      step();
      n++;
    end
  endtask

  initial begin
    #30_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int d0, b0, bp, n;
    bus.s_act_valid   = 1'b0;
    bus.s_act_data    = '0;
    bus.actbuf_wr_req = 1'b0;

    // Reset values while rst_n is held low.
    #2;
    check("rst_vld", 64'(bus.actbuf_wr_vld), 64'd0);
    check("rst_data", 64'(bus.actbuf_wr_data), 64'd0);
    check("rst_status", 64'(status_feed), 64'd0);
    check("rst_done", 64'(feed_done), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_ready", 64'(bus.s_act_ready), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("ready_after_reset", 64'(bus.s_act_ready), 64'd1);

    // Upstream valid every third cycle, tile of 8, empty FIFO at start.
    bus.actbuf_wr_req = 1'b1;
    d0 = done_seen; b0 = beats_seen;
    cfg_tile_words = 16'd8;
    cfg_start = 1'b1;
    up_mode = 2; up_ph = 1;
    run_until_done(d0, 200, "t_sparse");
    check("t_sparse_beats", 64'(beats_seen - b0), 64'd8);
    check("t_sparse_stall", 64'(last_done_stall), 64'd16);
    up_mode = 0;
    step(); step();

    // Zero-length tile: feed_done one cycle after start, no beats.
    bus.actbuf_wr_req = 1'b0;
    b0 = beats_seen;
    start_tile(0);
    #3;
    check("t_zero_done", 64'(feed_done), 64'd1);
    check("t_zero_status", 64'(status_feed), 64'd0);
    step();
    #3;
    check("t_zero_done_clear", 64'(feed_done), 64'd0);
    check("t_zero_beats", 64'(beats_seen - b0), 64'd0);

    // Start during FEED is ignored: tile of 5 stays 5 beats.
    up_mode = 1;
    d0 = done_seen; b0 = beats_seen;
    start_tile(5);
    step(); step(); step();
    cfg_tile_words = 16'd20;
    cfg_start = 1'b1;
    step();
    bus.actbuf_wr_req = 1'b1;
    run_until_done(d0, 200, "t_ignore");
    check("t_ignore_beats", 64'(beats_seen - b0), 64'd5);

    // Prefilled FIFO, tile of 27, request held: 27 back-to-back beats.
    bus.actbuf_wr_req = 1'b0;
    repeat (8) step();
    check("t_prefill_full", 64'(bus.s_act_ready), 64'd0);
    bus.actbuf_wr_req = 1'b1;
    run_max = 0;
    d0 = done_seen; b0 = beats_seen;
    start_tile(27);
    run_until_done(d0, 200, "t_full");
    check("t_full_beats", 64'(beats_seen - b0), 64'd27);
    check("t_full_run", 64'(run_max), 64'd27);

    // Request dropped for 5 cycles after beat 10.
    repeat (6) step();
    d0 = done_seen; b0 = beats_seen;
    start_tile(27);
    wait_beats(b0, 10);
    bus.actbuf_wr_req = 1'b0;
    #5;
    bp = beats_seen;
    repeat (5) step();
    #5;
    check("t_pause_no_vld", 64'(beats_seen - bp), 64'd0);
    bus.actbuf_wr_req = 1'b1;
    run_until_done(d0, 200, "t_pause");
    check("t_pause_beats", 64'(beats_seen - b0), 64'd27);

    // Reset at beat 5 of 27 aborts the tile.
    repeat (6) step();
    d0 = done_seen; b0 = beats_seen;
    start_tile(27);
    wait_beats(b0, 5);
    rst_n = 1'b0;
    #1;
    check("t_rst_vld", 64'(bus.actbuf_wr_vld), 64'd0);
    check("t_rst_data", 64'(bus.actbuf_wr_data), 64'd0);
    check("t_rst_status", 64'(status_feed), 64'd0);
    check("t_rst_done", 64'(feed_done), 64'd0);
    check("t_rst_stall", 64'(stall_cnt), 64'd0);
    check("t_rst_ready", 64'(bus.s_act_ready), 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (8) step();
    check("t_rst_no_done", 64'(done_seen - d0), 64'd0);
    d0 = done_seen; b0 = beats_seen;
    start_tile(6);
    run_until_done(d0, 200, "t_after_rst");
    check("t_after_rst_beats", 64'(beats_seen - b0), 64'd6);

    // Randomized traffic: random upstream, random request, stray starts.
    up_mode  = 3;
    req_rand = 1;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, 40);
      repeat ($urandom_range(0, 5)) step();
      cfg_rand = 0;
      d0 = done_seen; b0 = beats_seen;
      start_tile(n);
      cfg_rand = 1;
      run_until_done(d0, 2000, "t_rand");
      cfg_rand = 0;
      check("t_rand_beats", 64'(beats_seen - b0), 64'(n));
    end
    req_rand = 0;
    up_mode  = 0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
